// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, decode table and helpers for the keypad debouncer.
//   kp_state_t  - debounce FSM states
//   key_code_t  - 4-bit hex key code
//   KEY_TABLE   - hex code per key, indexed {row_idx, col_idx}
//   is_onehot4  - true when exactly one bit of a nibble is set
//   onehot_idx  - bit index of a one-hot nibble
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_t;

  typedef logic [3:0] key_code_t;

  // Row-major keypad legend: row 0 is the top row, col 0 the leftmost column.
  localparam key_code_t KEY_TABLE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// keypad_decode: combinational classifier/decoder for one scanner sample.
//   sample [7:0] in  - [7:4] one-hot row, [3:0] one-hot column
//   valid        out - both nibbles are one-hot
//   code   [3:0] out - hex code from the keypad table (don't-care when !valid)
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [7:0] sample,
  output logic       valid,
  output key_code_t  code
);

  logic [1:0] row_idx_s;
  logic [1:0] col_idx_s;

  // Classify the sample and look up its legend.
  always_comb begin
    valid     = is_onehot4(sample[7:4]) && is_onehot4(sample[3:0]);
    row_idx_s = onehot_idx(sample[7:4]);
    col_idx_s = onehot_idx(sample[3:0]);
    code      = KEY_TABLE[{row_idx_s, col_idx_s}];
  end

endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-based press/release debouncer with key lockout and a
// two-digit display history.
//   clk        in  - system clock
//   reset      in  - synchronous, active-low reset
//   key_val    in  - scanner sample ([7:4] row one-hot, [3:0] col one-hot)
//   key_valid  in  - qualifies key_val
//   key_new    out - one-cycle pulse per accepted key event
//   key_code   out - hex code of the last accepted key
//   digit_new  out - most recent key (right digit)
//   digit_old  out - previous key (left digit)
//   key_held   out - key accepted and not yet released
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat every REPEAT_FRAMES
// held frames; without it REPEAT_FRAMES is ignored.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4096,
  parameter int REPEAT_FRAMES   = 32768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_val,
  input  logic       key_valid,
  output logic       key_new,
  output key_code_t  key_code,
  output key_code_t  digit_new,
  output key_code_t  digit_old,
  output logic       key_held
);

  localparam int MAX_FRAMES = (DEBOUNCE_FRAMES > REPEAT_FRAMES) ? DEBOUNCE_FRAMES : REPEAT_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_FRAMES);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] REP_C = CW'(REPEAT_FRAMES);
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE_C;
  endfunction

  kp_state_t     state_r;
  logic [CW-1:0] cnt_r;
  key_code_t     cand_r;
  logic [1:0]    phase_r;
  logic          acc_valid_r;
  logic          acc_inv_r;
  key_code_t     acc_code_r;
`ifdef KEYPAD_REPEAT_EN
  logic [CW-1:0] rep_r;
`endif

  logic          samp_valid_s;
  key_code_t     samp_code_s;
  logic          cur_valid_s;
  logic          cur_inv_s;
  logic          frame_end_s;
  logic          frm_valid_s;
  logic          frm_present_s;
  key_code_t     frm_code_s;
  logic [CW-1:0] cnt_inc_s;

  keypad_decode u_decode (
    .sample (key_val),
    .valid  (samp_valid_s),
    .code   (samp_code_s)
  );

  // Merge the current sample into the running frame result; the first valid
  // sample wins, and the frame-end sample takes part in the decision.
  always_comb begin
    cur_valid_s   = key_valid & samp_valid_s;
    cur_inv_s     = key_valid & ~samp_valid_s;
    frame_end_s   = (phase_r == 2'd3);
    frm_valid_s   = acc_valid_r | cur_valid_s;
    frm_present_s = frm_valid_s | acc_inv_r | cur_inv_s;
    frm_code_s    = acc_valid_r ? acc_code_r : samp_code_s;
    cnt_inc_s     = sat_inc(cnt_r);
  end

  // Free-running frame phase and per-frame sample accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_r     <= 2'd0;
      acc_valid_r <= 1'b0;
      acc_inv_r   <= 1'b0;
      acc_code_r  <= 4'd0;
    end else begin
      phase_r <= phase_r + 2'd1;
      if (frame_end_s) begin
        acc_valid_r <= 1'b0;
        acc_inv_r   <= 1'b0;
        acc_code_r  <= 4'd0;
      end else begin
        if (!acc_valid_r && cur_valid_s) begin
          acc_valid_r <= 1'b1;
          acc_code_r  <= samp_code_s;
        end
        acc_inv_r <= acc_inv_r | cur_inv_s;
      end
    end
  end

  // Debounce FSM with registered event/display outputs, stepped once per frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      cand_r    <= 4'd0;
      key_new   <= 1'b0;
      key_code  <= 4'd0;
      digit_new <= 4'd0;
      digit_old <= 4'd0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_r     <= '0;
`endif
    end else begin
      key_new <= 1'b0;
      if (frame_end_s) begin
        case (state_r)
          ST_IDLE: begin
            if (frm_valid_s) begin
              cand_r  <= frm_code_s;
              cnt_r   <= ONE_C;
              state_r <= ST_PRESS_WAIT;
            end
          end
          ST_PRESS_WAIT: begin
            if (frm_valid_s && (frm_code_s == cand_r)) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s >= DEB_C) begin
                key_code  <= cand_r;
                digit_old <= digit_new;
                digit_new <= cand_r;
                key_new   <= 1'b1;
                key_held  <= 1'b1;
                state_r   <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_r     <= '0;
`endif
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_HELD: begin
            // Any present frame, whatever the key, keeps the lockout.
            if (!frm_present_s) begin
              cnt_r   <= ONE_C;
              state_r <= ST_RELEASE_WAIT;
`ifdef KEYPAD_REPEAT_EN
              rep_r   <= '0;
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (sat_inc(rep_r) >= REP_C) begin
                rep_r     <= '0;
                key_code  <= cand_r;
                digit_old <= digit_new;
                digit_new <= cand_r;
                key_new   <= 1'b1;
              end else begin
                rep_r <= sat_inc(rep_r);
              end
`else
              state_r <= ST_HELD;
`endif
            end
          end
          ST_RELEASE_WAIT: begin
            if (!frm_present_s) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s >= DEB_C) begin
                key_held <= 1'b0;
                state_r  <= ST_IDLE;
              end
            end else begin
              state_r <= ST_HELD;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            key_held <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
module tb_keypad_debounce;

  logic       clk;
  logic       reset;
  logic [7:0] key_val;
  logic       key_valid;
  logic       key_new;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_held;

  int n_cmp;
  int n_err;
  int kn_cnt;
  int base;
  int exp_rep;

  keypad_debounce #(
    .DEBOUNCE_FRAMES (4),
    .REPEAT_FRAMES   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_val   (key_val),
    .key_valid (key_valid),
    .key_new   (key_new),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count key_new pulses away from the active edge.
  always @(negedge clk) begin
    if (key_new === 1'b1) kn_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n whole frames; the scanner asserts key_valid at phase 2 when present.
  task automatic frames(input logic [7:0] v, input logic present, input int n);
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < 4; p++) begin
        key_val   = v;
        key_valid = present && (p == 2);
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Frames carrying an invalid sample at phase 0 and a valid 8'h24 at phase 2.
  task automatic mixed_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < 4; p++) begin
        key_val   = (p == 0) ? 8'h13 : 8'h24;
        key_valid = (p == 0) || (p == 2);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; kn_cnt = 0;
    key_val = 8'h00; key_valid = 1'b0; reset = 1'b0;
    #1;

    // Reset state
    do_reset(3);
    check("rst_key_new",   {7'd0, key_new},   8'h00);
    check("rst_key_code",  {4'd0, key_code},  8'h00);
    check("rst_digit_new", {4'd0, digit_new}, 8'h00);
    check("rst_digit_old", {4'd0, digit_old}, 8'h00);
    check("rst_key_held",  {7'd0, key_held},  8'h00);
    reset = 1'b1;

    // Clean press of key '1'
    base = kn_cnt;
    frames(8'h11, 1'b1, 3);
    check("press1_early", {7'd0, key_held}, 8'h00);
    frames(8'h11, 1'b1, 1);
    check("press1_pulse",  {7'd0, key_new},   8'h01);
    check("press1_code",   {4'd0, key_code},  8'h01);
    check("press1_dnew",   {4'd0, digit_new}, 8'h01);
    check("press1_dold",   {4'd0, digit_old}, 8'h00);
    check("press1_held",   {7'd0, key_held},  8'h01);
    frames(8'h11, 1'b1, 2);
    check("press1_count",  8'(kn_cnt - base), 8'h01);
    check("press1_nopulse", {7'd0, key_new}, 8'h00);

    // Release: held through three absent frames, drops on the fourth
    frames(8'h00, 1'b0, 3);
    check("rel1_still_held", {7'd0, key_held}, 8'h01);
    frames(8'h00, 1'b0, 1);
    check("rel1_done", {7'd0, key_held}, 8'h00);

    // Second key '0' shifts the history
    base = kn_cnt;
    frames(8'h82, 1'b1, 4);
    check("press0_pulse", {7'd0, key_new},   8'h01);
    check("press0_code",  {4'd0, key_code},  8'h00);
    check("press0_dnew",  {4'd0, digit_new}, 8'h00);
    check("press0_dold",  {4'd0, digit_old}, 8'h01);
    frames(8'h00, 1'b0, 4);
    check("press0_count", 8'(kn_cnt - base), 8'h01);
    check("rel0_done", {7'd0, key_held}, 8'h00);

    // Bounce on key '6': 2 present, 1 absent, 2 present
    base = kn_cnt;
    frames(8'h24, 1'b1, 2);
    frames(8'h00, 1'b0, 1);
    frames(8'h24, 1'b1, 2);
    frames(8'h00, 1'b0, 1);
    check("bounce_count", 8'(kn_cnt - base), 8'h00);
    check("bounce_code",  {4'd0, key_code},  8'h00);

    // Multi-key press is never accepted
    base = kn_cnt;
    frames(8'h13, 1'b1, 8);
    frames(8'h00, 1'b0, 1);
    check("invalid_count", 8'(kn_cnt - base), 8'h00);
    check("invalid_held",  {7'd0, key_held},  8'h00);

    // Valid sample wins over an invalid one in the same frame
    base = kn_cnt;
    mixed_frames(4);
    check("mixed_pulse", {7'd0, key_new},   8'h01);
    check("mixed_code",  {4'd0, key_code},  8'h06);
    check("mixed_dold",  {4'd0, digit_old}, 8'h00);
    frames(8'h00, 1'b0, 4);
    check("mixed_count", 8'(kn_cnt - base), 8'h01);

    // Lockout: '1' held, then 'A' pressed, then short release and re-press
    base = kn_cnt;
    frames(8'h11, 1'b1, 4);
    check("lock_code", {4'd0, key_code}, 8'h01);
    frames(8'h18, 1'b1, 4);
    check("lock_other_count", 8'(kn_cnt - base), 8'h01);
    check("lock_other_code",  {4'd0, key_code},  8'h01);
    frames(8'h00, 1'b0, 2);
    frames(8'h11, 1'b1, 1);
    check("lock_reheld", {7'd0, key_held}, 8'h01);
    frames(8'h00, 1'b0, 3);
    check("lock_rw_held", {7'd0, key_held}, 8'h01);
    frames(8'h00, 1'b0, 1);
    check("lock_count", 8'(kn_cnt - base), 8'h01);
    check("lock_released", {7'd0, key_held}, 8'h00);

    // Reset during the third debounce frame discards the press
    base = kn_cnt;
    frames(8'h48, 1'b1, 2);
    key_valid = 1'b0;
    do_reset(4);
    check("midrst_dnew", {4'd0, digit_new}, 8'h00);
    check("midrst_code", {4'd0, key_code},  8'h00);
    reset = 1'b1;
    frames(8'h48, 1'b1, 2);
    frames(8'h00, 1'b0, 1);
    check("midrst_count", 8'(kn_cnt - base), 8'h00);

    // Long hold of 'C': press at frame 4, repeats (if built in) at frames 12 and 20
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    base = kn_cnt;
    frames(8'h48, 1'b1, 20);
    check("hold_code",  {4'd0, key_code}, 8'h0C);
    frames(8'h00, 1'b0, 4);
    check("hold_count", 8'(kn_cnt - base), 8'(exp_rep));
    check("hold_released", {7'd0, key_held}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
